// File: rtl/lsu_wbuf_if.sv
// Scheduler / ALU / memory-bus signal bundle for lsu_wbuf.
// slave: the LSU side. master: the scheduler, ALU and memory side.
interface lsu_wbuf_if #(
    parameter int unsigned AW = 16,
    parameter int unsigned DW = 16
) ();
    logic          sched_ld;
    logic          sched_st;
    logic [AW-1:0] sched_addr;
    logic [DW-1:0] sched_wdata;
    logic          sched_ack;
    logic          ld_rdy;
    logic [DW-1:0] ld_data;
    logic          rmw_data_rdy;
    logic [AW-1:0] rmw_addr;
    logic [DW-1:0] rmw_data;
    logic          rmw_deny_op;
    logic          rmw_hold;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_ack;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  sched_ld, sched_st, sched_addr, sched_wdata,
        input  rmw_data_rdy, rmw_addr, rmw_data, rmw_deny_op,
        input  mem_ack, mem_rdata,
        output sched_ack, ld_rdy, ld_data, rmw_hold,
        output mem_req, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output sched_ld, sched_st, sched_addr, sched_wdata,
        output rmw_data_rdy, rmw_addr, rmw_data, rmw_deny_op,
        output mem_ack, mem_rdata,
        input  sched_ack, ld_rdy, ld_data, rmw_hold,
        input  mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/lsu_wbuf.sv
// Load/store unit with an in-order write buffer and a single outstanding bus transaction.
// Loads bypass queued stores unless they alias a buffered address.
// Optional: define LSU_STORE_FWD_EN to serve aliasing loads from the youngest buffered store.
module lsu_wbuf #(
    parameter int unsigned WB_DEPTH = 4,
    parameter int unsigned AW       = 16,
    parameter int unsigned DW       = 16
) (
    input  logic       clk,
    input  logic       a_rst_n,
    lsu_wbuf_if.slave  bus
);
    localparam int unsigned PW = $clog2(WB_DEPTH);
    localparam int unsigned CW = $clog2(WB_DEPTH + 1);
    localparam logic [CW-1:0] Full    = CW'(WB_DEPTH);
    localparam logic [CW-1:0] StLimit = CW'(WB_DEPTH - 2);

    typedef enum logic [1:0] {StIdle, StRd, StWr} state_t;

    state_t        state, state_nxt;
    logic [AW-1:0] buf_addr [WB_DEPTH];
    logic [DW-1:0] buf_data [WB_DEPTH];
    logic          buf_rmw  [WB_DEPTH];
    logic [PW-1:0] head_q, tail_q;
    logic [CW-1:0] count_q, rmw_cnt_q;
    logic          ld_pend_q;
    logic [AW-1:0] ld_addr_q;
    logic [CW-1:0] drain_q;      // older entries that must retire before the pending load
    logic          ld_rdy_q;
    logic [DW-1:0] ld_data_q;
    logic [AW-1:0] mem_addr_q;
    logic [DW-1:0] mem_wdata_q;

    logic          hit;
    logic [CW-1:0] hit_pos;
    logic [DW-1:0] hit_data;
    logic          ld_acc, st_acc, fwd, new_ld, pend, enq, pop, rd_done;
    logic          issue_rd, issue_wr;
    logic [AW-1:0] pend_addr;
    logic [CW-1:0] drain;

    // Youngest live entry whose address matches the scheduler address.
    always_comb begin
        hit      = 1'b0;
        hit_pos  = '0;
        hit_data = '0;
        for (int unsigned i = 0; i < WB_DEPTH; i++) begin
            if (CW'(i) < count_q && buf_addr[head_q + PW'(i)] == bus.sched_addr) begin
                hit      = 1'b1;
                hit_pos  = CW'(i + 1);
                hit_data = buf_data[head_q + PW'(i)];
            end
        end
    end

    assign ld_acc = bus.sched_ld & ~bus.rmw_deny_op & (state == StIdle) & ~ld_pend_q;
    // RMW capture owns the reserved slot, so it wins over a same-cycle store.
    assign st_acc = bus.sched_st & ~bus.rmw_deny_op & (count_q <= StLimit) & ~bus.rmw_data_rdy;
`ifdef LSU_STORE_FWD_EN
    assign fwd = ld_acc & hit;
`else
    assign fwd = 1'b0;
`endif
    assign new_ld    = ld_acc & ~fwd;
    assign pend      = ld_pend_q | new_ld;
    assign pend_addr = new_ld ? bus.sched_addr : ld_addr_q;
    assign drain     = new_ld ? (hit ? hit_pos : '0) : drain_q;
    assign enq       = bus.rmw_data_rdy | st_acc;
    assign pop       = (state == StWr) & bus.mem_ack;
    assign rd_done   = (state == StRd) & bus.mem_ack;

    // Next-state: full buffer drains first, then an unblocked load, then the head store.
    always_comb begin
        state_nxt = state;
        issue_rd  = 1'b0;
        issue_wr  = 1'b0;
        unique case (state)
            StIdle: begin
                if (count_q == Full) begin
                    issue_wr = 1'b1;
                end else if (pend && drain == '0) begin
                    issue_rd = 1'b1;
                end else if (count_q != '0) begin
                    issue_wr = 1'b1;
                end
                if (issue_rd) state_nxt = StRd;
                if (issue_wr) state_nxt = StWr;
            end
            StRd:    if (bus.mem_ack) state_nxt = StIdle;
            StWr:    if (bus.mem_ack) state_nxt = StIdle;
            default: state_nxt = StIdle;
        endcase
    end

    // State, pointers, counters and pending-load tracking.
    always_ff @(posedge clk or negedge a_rst_n) begin
        if (!a_rst_n) begin
            state     <= StIdle;
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            rmw_cnt_q <= '0;
            ld_pend_q <= 1'b0;
            ld_addr_q <= '0;
            drain_q   <= '0;
        end else begin
            state     <= state_nxt;
            head_q    <= head_q + PW'(pop);
            tail_q    <= tail_q + PW'(enq);
            count_q   <= count_q + CW'(enq) - CW'(pop);
            rmw_cnt_q <= rmw_cnt_q + CW'(bus.rmw_data_rdy) - CW'(pop & buf_rmw[head_q]);
            ld_pend_q <= pend & ~issue_rd;
            ld_addr_q <= pend_addr;
            if (new_ld)                      drain_q <= drain;
            else if (pop && drain_q != '0)   drain_q <= drain_q - 1'b1;
        end
    end

    // Buffer storage; contents are don't-care outside the head..tail window.
    always_ff @(posedge clk) begin
        if (enq) begin
            buf_addr[tail_q] <= bus.rmw_data_rdy ? bus.rmw_addr : bus.sched_addr;
            buf_data[tail_q] <= bus.rmw_data_rdy ? bus.rmw_data : bus.sched_wdata;
            buf_rmw[tail_q]  <= bus.rmw_data_rdy;
        end
    end

    // Bus address/data latched on issue, load data latched on completion or forward.
    always_ff @(posedge clk or negedge a_rst_n) begin
        if (!a_rst_n) begin
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            ld_rdy_q    <= 1'b0;
            ld_data_q   <= '0;
        end else begin
            if (issue_rd) begin
                mem_addr_q <= pend_addr;
            end else if (issue_wr) begin
                mem_addr_q  <= buf_addr[head_q];
                mem_wdata_q <= buf_data[head_q];
            end
            ld_rdy_q <= rd_done | fwd;
            if (rd_done)  ld_data_q <= bus.mem_rdata;
            else if (fwd) ld_data_q <= hit_data;
        end
    end

    assign bus.sched_ack = ld_acc | st_acc;
    assign bus.ld_rdy    = ld_rdy_q;
    assign bus.ld_data   = ld_data_q;
    assign bus.rmw_hold  = (rmw_cnt_q != '0);
    assign bus.mem_req   = (state != StIdle);
    assign bus.mem_we    = (state == StWr);
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
endmodule
